// File: rtl/jtag_master.sv
// JTAG master: issues TAP reset, IR scans and DR scans of up to 32 bits on a
// divided TCK, capturing TDO into data_out.
module jtag_master #(
  parameter int unsigned DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  cmd,
  input  logic [5:0]  len,
  input  logic [31:0] data_in,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] data_out,
  output logic        tclk,
  output logic        tms,
  output logic        tdi,
  input  logic        tdo,
  output logic        trst
);

  localparam int unsigned CW = 8;
  localparam int unsigned LW = 6;
  localparam int unsigned DW = 32;
  localparam logic [CW-1:0] PH_LAST = CW'(DIV - 1);
  localparam logic [1:0] CMD_RESET = 2'd0;
  localparam logic [1:0] CMD_IR    = 2'd1;
  localparam logic [1:0] CMD_DR    = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    RESET_SEQ,
    PRE,
    SHIFT,
    POST,
    FINISH
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] ph_q, ph_d;
  logic [LW-1:0] step_q, step_d;
  logic [LW-1:0] len_q, len_d;
  logic [DW-1:0] data_q, data_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          is_ir_q, is_ir_d;
  logic          tclk_q, tclk_d;
  logic          tms_q, tms_d;
  logic          tdi_q, tdi_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          trst_q, trst_d;

  logic          tick;
  logic          tck_end;
  logic          running;
  logic          finish;
  logic          bad_scan;
  logic          last_shift;
  logic [LW-1:0] step_inc;
  logic [LW-1:0] pre_last;

  // tick marks the last clk cycle of a TCK half-period
  assign tick       = (ph_q == PH_LAST);
  assign tck_end    = tick & tclk_q;
  assign running    = (state_q == RESET_SEQ) || (state_q == PRE) ||
                      (state_q == SHIFT) || (state_q == POST);
  assign bad_scan   = (cmd != CMD_RESET) &&
                      ((cmd != CMD_IR && cmd != CMD_DR) ||
                       (len == LW'(0)) || (len > LW'(DW)));
  assign step_inc   = step_q + LW'(1);
  assign last_shift = (step_q == (len_q - LW'(1)));
  assign pre_last   = is_ir_q ? LW'(3) : LW'(2);
  assign trst_d     = 1'b1;

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    step_d  = step_q;
    len_d   = len_q;
    data_d  = data_q;
    dout_d  = dout_q;
    is_ir_d = is_ir_q;
    tclk_d  = tclk_q;
    tms_d   = tms_q;
    tdi_d   = tdi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    finish  = 1'b0;

    if (running) begin
      ph_d = tick ? '0 : ph_q + CW'(1);
      if (tick) tclk_d = ~tclk_q;
    end

    // TMS/TDI advance only when a TCK ends, i.e. on the edge driving tclk low
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = len;
          data_d  = data_in;
          is_ir_d = (cmd == CMD_IR);
          step_d  = '0;
          ph_d    = '0;
          tclk_d  = 1'b0;
          tdi_d   = 1'b0;
          if (cmd == CMD_RESET) begin
            state_d = RESET_SEQ;
            busy_d  = 1'b1;
            tms_d   = 1'b1;
          end else if (bad_scan) begin
            state_d = FINISH;
            dout_d  = '0;
            done_d  = 1'b1;
            err_d   = 1'b1;
            tms_d   = 1'b0;
          end else begin
            state_d = PRE;
            busy_d  = 1'b1;
            tms_d   = 1'b1;
            dout_d  = '0;
          end
        end
      end
      RESET_SEQ: begin
        if (tck_end) begin
          if (step_q == LW'(5)) begin
            finish = 1'b1;
          end else begin
            step_d = step_inc;
            tms_d  = (step_inc != LW'(5));
          end
        end
      end
      PRE: begin
        if (tck_end) begin
          if (step_q == pre_last) begin
            state_d = SHIFT;
            step_d  = '0;
            tms_d   = (len_q == LW'(1));
            tdi_d   = data_q[0];
          end else begin
            step_d = step_inc;
            tms_d  = is_ir_q && (step_q == LW'(0));
          end
        end
      end
      SHIFT: begin
        if (tck_end) begin
          dout_d[step_q[4:0]] = tdo;
          if (last_shift) begin
            state_d = POST;
            step_d  = '0;
            tms_d   = 1'b1;
            tdi_d   = 1'b0;
          end else begin
            step_d = step_inc;
            tdi_d  = data_q[step_inc[4:0]];
            tms_d  = (step_inc == (len_q - LW'(1)));
          end
        end
      end
      POST: begin
        if (tck_end) begin
          if (step_q == LW'(0)) begin
            step_d = LW'(1);
            tms_d  = 1'b0;
          end else begin
            finish = 1'b1;
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (finish) begin
      state_d = FINISH;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      tms_d   = 1'b0;
      tdi_d   = 1'b0;
      tclk_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ph_q    <= '0;
      step_q  <= '0;
      len_q   <= '0;
      data_q  <= '0;
      dout_q  <= '0;
      is_ir_q <= 1'b0;
      tclk_q  <= 1'b0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      trst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      step_q  <= step_d;
      len_q   <= len_d;
      data_q  <= data_d;
      dout_q  <= dout_d;
      is_ir_q <= is_ir_d;
      tclk_q  <= tclk_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      trst_q  <= trst_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign data_out = dout_q;
  assign tclk     = tclk_q;
  assign tms      = tms_q;
  assign tdi      = tdi_q;
  assign trst     = trst_q;

endmodule

// File: tb/tb_jtag_master.sv
// Bench for jtag_master: a behavioural TAP target plus a cycle-level model of
// the expected pin and status behaviour, driven by directed and random commands.
module tb_jtag_master;

  localparam int unsigned DIV = 2;
  localparam int unsigned PER = 2 * DIV;
  localparam logic [31:0] IDCODE     = 32'h1BEEF001;
  localparam logic [5:0]  IR_CAPTURE = 6'h01;
  localparam logic [5:0]  IR_BYPASS  = 6'h3F;
  localparam logic [5:0]  IR_IDCODE  = 6'h02;

  localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5,
                 PSDR = 6, EX2DR = 7, UPDR = 8, SELIR = 9, CAPIR = 10,
                 SHIR = 11, EX1IR = 12, PSIR = 13, EX2IR = 14, UPIR = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  cmd = 2'd0;
  logic [5:0]  len = 6'd0;
  logic [31:0] data_in = 32'd0;
  logic        busy, done, err, tclk, tms, tdi, trst;
  logic [31:0] data_out;
  logic        tdo = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  jtag_master #(.DIV(DIV)) dut (
    .clk(clk), .rst(rst), .start(start), .cmd(cmd), .len(len),
    .data_in(data_in), .busy(busy), .done(done), .err(err),
    .data_out(data_out), .tclk(tclk), .tms(tms), .tdi(tdi), .tdo(tdo),
    .trst(trst)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- target TAP model ----------------
  function automatic int tap_next(input int s, input logic m);
    case (s)
      TLR:     return m ? TLR   : RTI;
      RTI:     return m ? SELDR : RTI;
      SELDR:   return m ? SELIR : CAPDR;
      CAPDR:   return m ? EX1DR : SHDR;
      SHDR:    return m ? EX1DR : SHDR;
      EX1DR:   return m ? UPDR  : PSDR;
      PSDR:    return m ? EX2DR : PSDR;
      EX2DR:   return m ? UPDR  : SHDR;
      UPDR:    return m ? SELDR : RTI;
      SELIR:   return m ? TLR   : CAPIR;
      CAPIR:   return m ? EX1IR : SHIR;
      SHIR:    return m ? EX1IR : SHIR;
      EX1IR:   return m ? UPIR  : PSIR;
      PSIR:    return m ? EX2IR : PSIR;
      EX2IR:   return m ? UPIR  : SHIR;
      UPIR:    return m ? SELDR : RTI;
      default: return TLR;
    endcase
  endfunction

  int          tap_st = TLR;
  logic [5:0]  tap_ir = IR_IDCODE;
  logic [5:0]  ir_sr  = 6'd0;
  logic [31:0] dr_sr  = 32'd0;
  logic        tap_byp = 1'b0;
  int          tck_edges = 0;

  always @(posedge tclk or negedge trst) begin
    if (!trst) begin
      tap_st = TLR;
      tap_ir = IR_IDCODE;
    end else begin
      tck_edges++;
      case (tap_st)
        TLR:   tap_ir = IR_IDCODE;
        CAPDR: begin tap_byp = (tap_ir == IR_BYPASS); dr_sr = tap_byp ? 32'd0 : IDCODE; end
        SHDR:  dr_sr = tap_byp ? {31'd0, tdi} : {tdi, dr_sr[31:1]};
        CAPIR: ir_sr = IR_CAPTURE;
        SHIR:  ir_sr = {tdi, ir_sr[5:1]};
        UPIR:  tap_ir = ir_sr;
        default: ;
      endcase
      tap_st = tap_next(tap_st, tms);
    end
  end

  always @(negedge tclk)
    tdo = (tap_st == SHDR) ? dr_sr[0] : (tap_st == SHIR) ? ir_sr[0] : 1'b0;

  // ---------------- expected-behaviour model ----------------
  bit          m_act = 1'b0;
  int          m_c = 0;
  int          m_n = 0;
  bit          m_tms [64];
  bit          m_tdi [64];
  logic        m_err = 1'b0;
  logic [31:0] m_dout = 32'd0;
  logic [31:0] m_res = 32'd0;
  logic        m_idle_tms = 1'b1;
  logic        m_trst = 1'b0;
  logic [5:0]  m_ir = IR_IDCODE;

  function automatic logic [31:0] len_mask(input int l);
    return (l >= 32) ? 32'hFFFF_FFFF : ((32'd1 << l) - 32'd1);
  endfunction

  task automatic model_accept(input logic [1:0] c, input logic [5:0] l, input logic [31:0] d);
    int pre;
    logic [37:0] cat;
    m_act = 1'b1;
    m_c   = 0;
    m_err = 1'b0;
    for (int i = 0; i < 64; i++) begin m_tms[i] = 1'b0; m_tdi[i] = 1'b0; end
    if (c == 2'd0) begin
      m_n = 6;
      for (int i = 0; i < 5; i++) m_tms[i] = 1'b1;
      m_ir  = IR_IDCODE;
      m_res = m_dout;
    end else if (c == 2'd3 || l == 6'd0 || l > 6'd32) begin
      m_n = 0; m_err = 1'b1; m_dout = 32'd0; m_res = 32'd0;
    end else begin
      pre = (c == 2'd1) ? 4 : 3;
      m_tms[0] = 1'b1;
      if (c == 2'd1) m_tms[1] = 1'b1;
      for (int k = 0; k < int'(l); k++) begin
        m_tms[pre + k] = (k == int'(l) - 1);
        m_tdi[pre + k] = d[k];
      end
      m_tms[pre + int'(l)] = 1'b1;
      m_n    = pre + int'(l) + 2;
      m_dout = 32'd0;
      if (c == 2'd1) begin
        cat   = {d, IR_CAPTURE};
        m_res = cat[31:0] & len_mask(int'(l));
        m_ir  = 6'(cat >> l);
      end else if (m_ir == IR_BYPASS) begin
        m_res = {d[30:0], 1'b0} & len_mask(int'(l));
      end else begin
        m_res = IDCODE & len_mask(int'(l));
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act = 1'b0; m_dout = 32'd0; m_idle_tms = 1'b1; m_trst = 1'b0;
    end else begin
      m_trst = 1'b1;
      if (m_act) begin
        m_c++;
        if (m_c > int'(PER) * m_n) begin
          m_act = 1'b0; m_dout = m_res; m_idle_tms = 1'b0;
        end
      end else if (start) begin
        model_accept(cmd, len, data_in);
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_tclk"}, tclk, 0);
    check({tag, "_tms"},  tms, 1);
    check({tag, "_tdi"},  tdi, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"},  err, 0);
    check({tag, "_dout"}, data_out, 0);
    check({tag, "_trst"}, trst, 0);
  endtask

  // compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    int j;
    if (rst) begin
      check_reset_vals("rst");
    end else begin
      check("trst", trst, m_trst);
      if (m_act && m_c < int'(PER) * m_n) begin
        j = m_c / int'(PER);
        check("run_busy", busy, 1);
        check("run_done", done, 0);
        check("run_tclk", tclk, ((m_c % int'(PER)) >= int'(DIV)) ? 1 : 0);
        check("run_tms",  tms, m_tms[j]);
        check("run_tdi",  tdi, m_tdi[j]);
      end else if (m_act) begin
        check("fin_done", done, 1);
        check("fin_busy", busy, 0);
        check("fin_err",  err, m_err);
        check("fin_tclk", tclk, 0);
        check("fin_tms",  tms, 0);
        check("fin_tdi",  tdi, 0);
        check("fin_dout", data_out, m_res);
      end else begin
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_err",  err, 0);
        check("idle_tclk", tclk, 0);
        check("idle_tms",  tms, m_idle_tms);
        check("idle_tdi",  tdi, 0);
        check("idle_dout", data_out, m_dout);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [1:0] c, input logic [5:0] l, input logic [31:0] d,
                       input int glitch_at, output int tcks, output logic [31:0] dout,
                       output logic e, output int lat);
    tck_edges = 0;
    start = 1'b1; cmd = c; len = l; data_in = d;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 400) begin
      if (glitch_at > 0 && lat == glitch_at) begin
        start = 1'b1; cmd = 2'd3; len = 6'd0; data_in = 32'hFFFF_FFFF;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    if (done !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL done_timeout: got done=%b after %0d cycles, expected a done pulse", done, lat);
    end
    tcks = tck_edges; dout = data_out; e = err;
    @(posedge clk); #1;
  endtask

  initial begin
    int tcks, lat, kind, exp_tcks;
    logic [31:0] dout, d;
    logic e;
    logic [1:0] c;
    logic [5:0] l;

    repeat (3) @(posedge clk);
    #2;
    check_reset_vals("por");
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("trst_after_rst", trst, 1);

    issue(2'd0, 6'd0, 32'd0, 0, tcks, dout, e, lat);
    check("reset_tcks", tcks, 6);
    check("reset_lat", lat, 24);
    check("reset_tap_rti", tap_st, RTI);

    issue(2'd2, 6'd32, 32'd0, 0, tcks, dout, e, lat);
    check("idcode_tcks", tcks, 37);
    check("idcode_dout", dout, 32'h1BEEF001);
    check("idcode_err", e, 0);

    issue(2'd1, 6'd6, 32'h3F, 0, tcks, dout, e, lat);
    check("ir_tcks", tcks, 12);
    check("ir_dout", dout, 32'h01);
    check("ir_tap_ir", tap_ir, 32'h3F);

    issue(2'd2, 6'd4, 32'hA, 0, tcks, dout, e, lat);
    check("bypass_dout", dout, 32'h4);
    check("bypass_tcks", tcks, 9);

    issue(2'd2, 6'd0, 32'h1234, 0, tcks, dout, e, lat);
    check("len0_tcks", tcks, 0);
    check("len0_err", e, 1);
    check("len0_dout", dout, 0);
    check("len0_lat", lat, 0);

    issue(2'd0, 6'd0, 32'd0, 0, tcks, dout, e, lat);
    issue(2'd2, 6'd32, 32'h5555_AAAA, 20, tcks, dout, e, lat);
    check("glitch_tcks", tcks, 37);
    check("glitch_dout", dout, 32'h1BEEF001);
    check("glitch_err", e, 0);

    // abort in the middle of shift bit 10 of a 32-bit scan
    issue(2'd0, 6'd0, 32'd0, 0, tcks, dout, e, lat);
    start = 1'b1; cmd = 2'd2; len = 6'd32; data_in = $urandom;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (int'(PER) * 13 + 1) @(posedge clk);
    #2;
    check("abort_busy", busy, 1);
    rst = 1'b1;
    #1;
    check_reset_vals("abort");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    issue(2'd0, 6'd0, 32'd0, 0, tcks, dout, e, lat);
    issue(2'd2, 6'd32, 32'd0, 0, tcks, dout, e, lat);
    check("post_abort_dout", dout, 32'h1BEEF001);

    // random commands; pin-level behaviour is checked every cycle
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 19);
      d = $urandom;
      if (kind < 2) begin
        c = 2'd0; l = 6'($urandom);
      end else if (kind < 5) begin
        c = 2'($urandom_range(1, 3));
        case ($urandom_range(0, 2))
          0:       l = 6'd0;
          1:       l = 6'($urandom_range(33, 63));
          default: begin c = 2'd3; l = 6'($urandom_range(1, 32)); end
        endcase
      end else if (kind < 11) begin
        c = 2'd1;
        l = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(1, 32)) : 6'd6;
        if ($urandom_range(0, 1) == 1) d[5:0] = 6'h3F;
      end else begin
        c = 2'd2; l = 6'($urandom_range(1, 32));
      end
      if (c == 2'd0)                                    exp_tcks = 6;
      else if (c == 2'd3 || l == 6'd0 || l > 6'd32)     exp_tcks = 0;
      else if (c == 2'd1)                               exp_tcks = int'(l) + 6;
      else                                              exp_tcks = int'(l) + 5;
      issue(c, l, d, 0, tcks, dout, e, lat);
      check("rand_tcks", tcks, exp_tcks);
      check("rand_err", e, (exp_tcks == 0) ? 1 : 0);
      check("rand_tap_rti", (exp_tcks == 0) ? RTI : tap_st, RTI);
    end

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, expected completion before 1ms");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/jtag_master.md
JTAG_MASTER -- requirements
Module: jtag_master

Interface
REQ-001 Parameter DIV, default 2, meaning TCK half-period in clk cycles (legal range 1..255).
REQ-002 clk  input  1  system clock; all logic on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  command request; sampled only while busy=0.
REQ-005 cmd  input  2  command type: 0=RESET, 1=IR_SCAN, 2=DR_SCAN, 3=reserved.
REQ-006 len  input  6  scan length in bits; legal range 1..32.
REQ-007 data_in  input  32  TDI payload, shifted LSB first.
REQ-008 busy  output  1  high from the cycle after an accepted start until done.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 err  output  1  valid with done; 1 = command rejected.
REQ-011 data_out  output  32  captured TDO bits; bit i = i-th shifted bit; bits >= len are 0.
REQ-012 tclk  output  1  JTAG test clock.
REQ-013 tms  output  1  JTAG mode select.
REQ-014 tdi  output  1  JTAG data to target.
REQ-015 tdo  input  1  JTAG data from target; the target updates it on the TCK falling edge.
REQ-016 trst  output  1  active-low target reset: 0 while rst is high, 1 from the first clk edge after rst deasserts.

Function
REQ-017 A TCK period shall be 2*DIV clk cycles:
- low phase of DIV cycles, then high phase of DIV cycles.
- tclk shall idle low.
REQ-018 tms and tdi shall change only on the clk edge that drives tclk low, or while tclk is idle.
REQ-019 tdo shall be sampled on the clk edge that ends each high phase.
REQ-020 start=1 with busy=0 shall latch cmd, len and data_in, then set busy=1 on the next edge.
REQ-021 The first TCK low phase shall begin on the same edge that sets busy.
REQ-022 start while busy=1 shall be ignored, with no effect on the current command.
REQ-023 The FSM shall have states IDLE, RESET_SEQ, PRE, SHIFT, POST, FINISH:
- IDLE -> RESET_SEQ (cmd=0) or PRE (cmd=1/2).
- PRE -> SHIFT -> POST -> FINISH.
- RESET_SEQ -> FINISH.
- FINISH -> IDLE after one cycle.
REQ-024 RESET shall drive TMS 1,1,1,1,1,0 over 6 TCKs, leaving the target in Run-Test/Idle.
REQ-025 DR_SCAN PRE shall drive TMS 1,0,0 over 3 TCKs.
REQ-026 IR_SCAN PRE shall drive TMS 1,1,0,0 over 4 TCKs.
REQ-027 SHIFT shall last len TCKs:
- tdi = data_in[k] on TCK k.
- tms = 0, except tms = 1 on the final shift TCK.
- tdo is captured into data_out[k].
REQ-028 POST shall drive TMS 1,0 over 2 TCKs (Update, then Run-Test/Idle).
REQ-029 TCK totals shall be: RESET 6, DR_SCAN len+5, IR_SCAN len+6.
REQ-030 tdi shall be 0 outside SHIFT.
REQ-031 In FINISH:
- done=1 and busy=0, tclk=0, tms=0.
- data_out is held stable until the next accepted start.
REQ-032 A scan with len=0, len>32 or cmd=3 shall generate no TCK:
- one cycle after acceptance, done=1, err=1, data_out=0.
REQ-033 data_out shall be cleared to 0 on acceptance of each scan command.
REQ-034 RESET shall leave data_out unchanged.

Reset
REQ-035 rst=1 shall immediately force:
- tclk=0, tms=1, tdi=0, busy=0, done=0, err=0, data_out=0, trst=0.
- FSM=IDLE.
REQ-036 rst asserted mid-command shall abort the command without a done pulse.
REQ-037 The target TAP state is undefined after an abort; software shall issue RESET before the next scan.

Verification (DIV=2, bench TAP model: IDCODE=0x1BEEF001, 6-bit IR capture value 0x01, BYPASS IR=0x3F)
REQ-038 RESET cmd -> 6 TCKs (24 clk) with tms 1,1,1,1,1,0; done one cycle later; model in Run-Test/Idle.
REQ-039 After RESET, DR_SCAN len=32 data_in=0 -> 37 TCKs; data_out=0x1BEEF001; err=0.
REQ-040 IR_SCAN len=6 data_in=0x3F -> 12 TCKs; data_out=0x01; model IR=0x3F.
REQ-041 Then DR_SCAN len=4 data_in=0xA -> data_out=0x4 (bypass one-bit delay).
REQ-042 DR_SCAN len=0 -> no tclk edge; done and err pulse together 1 cycle after start; second start during a 32-bit scan ignored.
REQ-043 rst pulsed at shift bit 10 of a 32-bit scan -> all outputs at reset values within the same cycle; no done; subsequent RESET + IDCODE scan returns 0x1BEEF001.
